// File: rtl/axis_out_buffer_if.sv
// ----------------------------------------------------------------------------
// axis_out_buffer_if
// AXI-Stream link between the layer output buffer and the next stage or DMA.
//   tdata  : stream word (DATA_SIZE bits), master -> slave
//   tvalid : word valid, master -> slave
//   tlast  : last word of the frame, master -> slave
//   tready : downstream can accept, slave -> master
// ----------------------------------------------------------------------------
interface axis_out_buffer_if #(
    parameter int DATA_SIZE = 16
);
    logic [DATA_SIZE-1:0] tdata;
    logic                 tvalid;
    logic                 tready;
    logic                 tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_out_buffer.sv
// ----------------------------------------------------------------------------
// axis_out_buffer
// Output-side buffer of a layer stage. The layer datapath fills OUT_COUNT
// words by address; a start pulse drains them in address order as a single
// AXI-Stream frame with tlast on the final word.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous, active-high reset
//   buf_wr    : write strobe from the layer datapath
//   buf_adr   : write address
//   buf_data  : write data
//   start     : one-cycle pulse, buffer complete -> begin streaming
//   busy      : high while a frame is being streamed
//   done      : one-cycle pulse after the last beat is accepted
//   wr_drop   : one-cycle pulse when a write was rejected
//   m_axis    : AXI-Stream master (tdata/tvalid/tlast out, tready in)
// ----------------------------------------------------------------------------
module axis_out_buffer #(
    parameter int OUT_COUNT = 10,
    parameter int DATA_SIZE = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         buf_wr,
    input  logic [$clog2(OUT_COUNT)-1:0] buf_adr,
    input  logic [DATA_SIZE-1:0]         buf_data,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         wr_drop,
    axis_out_buffer_if.master            m_axis
);
    localparam int               ADR_W    = $clog2(OUT_COUNT);
    localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(OUT_COUNT - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t               state;
    state_t               stateNext;
    logic [ADR_W-1:0]     rdPtr;
    logic [ADR_W-1:0]     nextPtr;
    logic [DATA_SIZE-1:0] mem [OUT_COUNT];
    logic [DATA_SIZE-1:0] tdataQ;
    logic                 tlastQ;
    logic                 launch;
    logic                 beatAccept;
    logic                 lastAccept;
    logic                 wrHit;
    logic                 wrReject;

    // ---- state register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start)      stateNext = STREAM;
            STREAM:  if (lastAccept) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // ---- output / strobe decode ----
    // tvalid and busy decode the state flop directly, so an asynchronous
    // reset drops them immediately without waiting for a clock.
    always_comb begin
        busy       = (state == STREAM);
        launch     = (state == IDLE) && start;
        beatAccept = busy && m_axis.tready;
        lastAccept = beatAccept && (rdPtr == LAST_ADR);
        nextPtr    = rdPtr + ADR_W'(1);
        // Writes only land while idle so an in-flight frame stays frozen.
        wrHit      = buf_wr && (state == IDLE) && (buf_adr <= LAST_ADR);
        wrReject   = buf_wr && !wrHit;
    end

    assign m_axis.tvalid = busy;
    assign m_axis.tdata  = tdataQ;
    assign m_axis.tlast  = tlastQ;

    // ---- storage ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OUT_COUNT; i++) begin
                mem[i] <= '0;
            end
        end else if (wrHit) begin
            mem[buf_adr] <= buf_data;
        end
    end

    // ---- read pointer and stream registers ----
    // The next word is preloaded on each handshake so tdata/tlast stay
    // registered and hold still across stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr   <= '0;
            tdataQ  <= '0;
            tlastQ  <= 1'b0;
            done    <= 1'b0;
            wr_drop <= 1'b0;
        end else begin
            done    <= lastAccept;
            wr_drop <= wrReject;
            if (launch) begin
                rdPtr  <= '0;
                tdataQ <= mem[0];
                tlastQ <= 1'b0;
            end else if (lastAccept) begin
                rdPtr  <= '0;
                tlastQ <= 1'b0;
            end else if (beatAccept) begin
                rdPtr  <= nextPtr;
                tdataQ <= mem[nextPtr];
                tlastQ <= (nextPtr == LAST_ADR);
            end
        end
    end
endmodule

// File: tb/tb_axis_out_buffer.sv
// ----------------------------------------------------------------------------
// tb_axis_out_buffer
// Directed bench for axis_out_buffer: table-driven cycle vectors for the
// main OUT_COUNT=10 instance plus hand-written sequences for asynchronous
// reset mid-frame and an OUT_COUNT=5 instance.
// Output tuple compared everywhere: {tvalid, tdata, tlast, busy, done, wr_drop}.
// ----------------------------------------------------------------------------
module tb_axis_out_buffer;
    localparam int N  = 10;
    localparam int N5 = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance (OUT_COUNT = 10)
    logic        wrA = 1'b0;
    logic [3:0]  adrA = '0;
    logic [15:0] dataA = '0;
    logic        startA = 1'b0;
    logic        busyA, doneA, dropA;
    axis_out_buffer_if #(.DATA_SIZE(16)) axA ();

    axis_out_buffer #(.OUT_COUNT(N), .DATA_SIZE(16)) dutA (
        .clk(clk), .rst(rst), .buf_wr(wrA), .buf_adr(adrA), .buf_data(dataA),
        .start(startA), .busy(busyA), .done(doneA), .wr_drop(dropA), .m_axis(axA)
    );

    // Sweep instance (OUT_COUNT = 5)
    logic        wrB = 1'b0;
    logic [2:0]  adrB = '0;
    logic [15:0] dataB = '0;
    logic        startB = 1'b0;
    logic        busyB, doneB, dropB;
    axis_out_buffer_if #(.DATA_SIZE(16)) axB ();

    axis_out_buffer #(.OUT_COUNT(N5), .DATA_SIZE(16)) dutB (
        .clk(clk), .rst(rst), .buf_wr(wrB), .buf_adr(adrB), .buf_data(dataB),
        .start(startB), .busy(busyB), .done(doneB), .wr_drop(dropB), .m_axis(axB)
    );

    typedef struct {
        logic        wr;
        logic [3:0]  adr;
        logic [15:0] data;
        logic        start;
        logic        rdy;
        logic [20:0] exp;
    } vec_t;

    vec_t rows[$];
    int   errors = 0;
    int   checks = 0;

    logic [15:0] inc [N];
    logic [15:0] zer [N];
    logic [15:0] wz  [N];

    function automatic logic [20:0] pk(logic v, logic [15:0] d, logic l,
                                       logic b, logic dn, logic dr);
        return {v, d, l, b, dn, dr};
    endfunction

    function automatic logic [20:0] gotA();
        return {axA.tvalid, axA.tdata, axA.tlast, busyA, doneA, dropA};
    endfunction

    function automatic logic [20:0] gotB();
        return {axB.tvalid, axB.tdata, axB.tlast, busyB, doneB, dropB};
    endfunction

    task automatic check(input string nm, input logic [20:0] got, input logic [20:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got v=%b d=%h l=%b busy=%b done=%b drop=%b, want v=%b d=%h l=%b busy=%b done=%b drop=%b",
                     nm, got[20], got[19:4], got[3], got[2], got[1], got[0],
                     want[20], want[19:4], want[3], want[2], want[1], want[0]);
        end
    endtask

    task automatic pushRow(input logic wr, input logic [3:0] adr, input logic [15:0] data,
                           input logic st, input logic rdy, input logic [20:0] exp);
        vec_t r;
        r.wr = wr; r.adr = adr; r.data = data; r.start = st; r.rdy = rdy; r.exp = exp;
        rows.push_back(r);
    endtask

    // Full frame with tready held high; the start row may carry a write.
    task automatic pushFrame(input logic [15:0] w [N], input logic wr,
                             input logic [3:0] adr, input logic [15:0] data);
        pushRow(wr, adr, data, 1'b1, 1'b1, pk(1'b1, w[0], 1'b0, 1'b1, 1'b0, 1'b0));
        for (int k = 1; k < N; k++)
            pushRow(1'b0, 4'd0, 16'h0, 1'b0, 1'b1, pk(1'b1, w[k], k == N-1, 1'b1, 1'b0, 1'b0));
        pushRow(1'b0, 4'd0, 16'h0, 1'b0, 1'b1, pk(1'b0, w[N-1], 1'b0, 1'b0, 1'b1, 1'b0));
    endtask

    task automatic idleA();
        wrA = 1'b0; adrA = '0; dataA = '0; startA = 1'b0; axA.tready = 1'b0;
    endtask

    // Drive each row for one clock, then compare the registered response.
    task automatic runRows(input string tag);
        foreach (rows[i]) begin
            wrA = rows[i].wr; adrA = rows[i].adr; dataA = rows[i].data;
            startA = rows[i].start; axA.tready = rows[i].rdy;
            @(posedge clk); #1;
            check($sformatf("%s[%0d]", tag, i), gotA(), rows[i].exp);
        end
        rows.delete();
        idleA();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation bound exceeded, got no finish want finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] patBits;
        int         idx;
        logic       r;
        logic       fin;

        for (int i = 0; i < N; i++) begin
            inc[i] = 16'(i + 1);
            zer[i] = 16'h0;
            wz[i]  = 16'h0;
        end
        wz[5] = 16'h1234;
        axA.tready = 1'b0;
        axB.tready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("resetA", gotA(), 21'd0);
        check("resetB", gotB(), 21'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Fill 1..10, reject an out-of-range address, stream with tready high
        for (int i = 0; i < N; i++)
            pushRow(1'b1, 4'(i), inc[i], 1'b0, 1'b0, 21'd0);
        pushRow(1'b1, 4'd12, 16'hFFFF, 1'b0, 1'b0, pk(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1));
        pushFrame(inc, 1'b0, 4'd0, 16'h0);
        pushRow(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, pk(1'b0, inc[N-1], 1'b0, 1'b0, 1'b0, 1'b0));
        runRows("basic");

        // Backpressure: tready pattern 1,0,0,1,0,1 repeating
        patBits = 6'b101001;
        pushRow(1'b0, 4'd0, 16'h0, 1'b1, 1'b0, pk(1'b1, inc[0], 1'b0, 1'b1, 1'b0, 1'b0));
        idx = 0;
        fin = 1'b0;
        for (int k = 0; k < 60 && !fin; k++) begin
            r = patBits[k % 6];
            if (r && idx == N-1) begin
                pushRow(1'b0, 4'd0, 16'h0, 1'b0, 1'b1, pk(1'b0, inc[N-1], 1'b0, 1'b0, 1'b1, 1'b0));
                fin = 1'b1;
            end else begin
                if (r) idx++;
                pushRow(1'b0, 4'd0, 16'h0, 1'b0, r, pk(1'b1, inc[idx], idx == N-1, 1'b1, 1'b0, 1'b0));
            end
        end
        pushRow(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, pk(1'b0, inc[N-1], 1'b0, 1'b0, 1'b0, 1'b0));
        runRows("bp");

        // Write while busy is dropped; starts while busy ignored; start with done chains
        pushRow(1'b0, 4'd0, 16'h0, 1'b1, 1'b1, pk(1'b1, inc[0], 1'b0, 1'b1, 1'b0, 1'b0));
        pushRow(1'b1, 4'd3, 16'hABCD, 1'b0, 1'b0, pk(1'b1, inc[0], 1'b0, 1'b1, 1'b0, 1'b1));
        for (int k = 1; k < N; k++)
            pushRow(1'b0, 4'd0, 16'h0, (k == 2 || k == N-1), 1'b1,
                    pk(1'b1, inc[k], k == N-1, 1'b1, 1'b0, 1'b0));
        pushRow(1'b0, 4'd0, 16'h0, 1'b0, 1'b1, pk(1'b0, inc[N-1], 1'b0, 1'b0, 1'b1, 1'b0));
        pushFrame(inc, 1'b0, 4'd0, 16'h0);
        pushRow(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, pk(1'b0, inc[N-1], 1'b0, 1'b0, 1'b0, 1'b0));
        runRows("drop");

        // Asynchronous reset after four accepted beats
        startA = 1'b1; axA.tready = 1'b1;
        @(posedge clk); #1;
        startA = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midframe", gotA(), pk(1'b1, inc[4], 1'b0, 1'b1, 1'b0, 1'b0));
        #3 rst = 1'b1;
        #1;
        check("async_rst", gotA(), 21'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("no_done[%0d]", k), gotA(), 21'd0);
        end
        idleA();

        // Cleared memory streams zeros; start with a write lands the word
        pushFrame(zer, 1'b0, 4'd0, 16'h0);
        pushRow(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 21'd0);
        pushFrame(wz, 1'b1, 4'd5, 16'h1234);
        pushRow(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 21'd0);
        runRows("post_rst");

        // OUT_COUNT = 5 instance
        for (int i = 0; i < N5; i++) begin
            wrB = 1'b1; adrB = 3'(i); dataB = 16'h0100 + 16'(i);
            @(posedge clk); #1;
        end
        adrB = 3'd6; dataB = 16'hDEAD;
        @(posedge clk); #1;
        wrB = 1'b0;
        check("sweep_drop", gotB(), pk(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1));
        startB = 1'b1; axB.tready = 1'b1;
        @(posedge clk); #1;
        startB = 1'b0;
        for (int b = 0; b < N5; b++) begin
            check($sformatf("sweep_beat%0d", b), gotB(),
                  pk(1'b1, 16'h0100 + 16'(b), b == N5-1, 1'b1, 1'b0, 1'b0));
            @(posedge clk); #1;
        end
        check("sweep_done", gotB(), pk(1'b0, 16'h0104, 1'b0, 1'b0, 1'b1, 1'b0));
        @(posedge clk); #1;
        check("sweep_idle", gotB(), pk(1'b0, 16'h0104, 1'b0, 1'b0, 1'b0, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
